// File: rtl/uart_lb_bridge.sv
// UART-to-local-bus bridge: assembles ctrl/addr/data byte frames into write or
// read strobes, and streams read results (ctrl echo + data) back to the UART.
module uart_lb_bridge #(
  parameter int LBCWIDTH = 8,
  parameter int LBAWIDTH = 24,
  parameter int LBDWIDTH = 32,
  parameter int RDLAT    = 2,
  parameter int TIMEOUT  = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [LBCWIDTH-1:0] lb_ctrl,
  output logic [LBAWIDTH-1:0] lb_addr,
  output logic [LBDWIDTH-1:0] lb_wdata,
  output logic                lb_wren,
  output logic                lb_rden,
  input  logic [LBDWIDTH-1:0] lb_rdata,
  output logic                busy,
  output logic                overrun
);
  localparam int ABYTES = LBAWIDTH / 8;
  localparam int DBYTES = LBDWIDTH / 8;
  localparam int TXBITS = LBCWIDTH + LBDWIDTH;
  localparam int TOW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, READ, RWAIT, TX} state_t;
  state_t state, state_nxt;

  logic [2:0]        bcnt;
  logic [3:0]        lat_cnt;
  logic [TOW-1:0]    idle_cnt;
  logic [TXBITS-1:0] tx_shift;
  logic              accept, framing, last_byte, timed_out, hs;

  assign framing   = (state == ADDR) || (state == WDATA);
  assign last_byte = ((state == ADDR)  && (bcnt == 3'(ABYTES - 1))) ||
                     ((state == WDATA) && (bcnt == 3'(DBYTES - 1)));
  assign timed_out = framing && !rx_valid && (idle_cnt == TOW'(TIMEOUT - 1));
  assign hs        = tx_valid & tx_ready;

  assign tx_valid = (state == TX);
  assign tx_data  = tx_shift[TXBITS-1 -: 8];
  assign lb_wren  = (state == WRITE);
  assign lb_rden  = (state == READ);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (rx_valid) begin
        accept    = 1'b1;
        state_nxt = ADDR;
      end
      ADDR, WDATA: begin
        if (rx_valid) begin
          accept = 1'b1;
          if (last_byte) begin
            if (state == WDATA)  state_nxt = WRITE;
            else if (lb_ctrl[0]) state_nxt = READ;
            else                 state_nxt = WDATA;
          end
        end else if (timed_out) begin
          state_nxt = IDLE;
        end
      end
      WRITE: state_nxt = IDLE;
      READ:  state_nxt = RWAIT;
      RWAIT: if (lat_cnt == 4'd1) state_nxt = TX;
      TX:    if (hs && (bcnt == 3'd4)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lb_ctrl  <= '0;
      lb_addr  <= '0;
      lb_wdata <= '0;
      bcnt     <= '0;
      lat_cnt  <= '0;
      idle_cnt <= '0;
      tx_shift <= '0;
      overrun  <= 1'b0;
    end else begin
      // any byte the frame parser did not take is lost for good
      overrun  <= overrun | (rx_valid & ~accept);
      idle_cnt <= (accept || !framing) ? '0 : idle_cnt + TOW'(1);
      case (state)
        IDLE: begin
          bcnt <= '0;
          if (accept) lb_ctrl <= rx_data;
        end
        ADDR: if (accept) begin
          lb_addr <= {lb_addr[LBAWIDTH-9:0], rx_data};
          bcnt    <= last_byte ? 3'd0 : bcnt + 3'd1;
        end
        WDATA: if (accept) begin
          lb_wdata <= {lb_wdata[LBDWIDTH-9:0], rx_data};
          bcnt     <= last_byte ? 3'd0 : bcnt + 3'd1;
        end
        READ: lat_cnt <= 4'(RDLAT);
        RWAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) tx_shift <= {lb_ctrl, lb_rdata};
        end
        TX: if (hs) begin
          tx_shift <= {tx_shift[TXBITS-9:0], 8'h00};
          bcnt     <= bcnt + 3'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_lb_bridge.sv
// Randomized bench for uart_lb_bridge: frames are described as transactions
// and compared against strobes and tx bytes predicted from the frame format.
module tb_uart_lb_bridge;
  localparam int RDLAT   = 2;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  lb_ctrl;
  logic [23:0] lb_addr;
  logic [31:0] lb_wdata;
  logic        lb_wren, lb_rden;
  logic [31:0] lb_rdata = '0;
  logic        busy, overrun;

  uart_lb_bridge #(.RDLAT(RDLAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .lb_ctrl(lb_ctrl), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .lb_wren(lb_wren), .lb_rden(lb_rden), .lb_rdata(lb_rdata),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [7:0]  ctrl;
    logic [23:0] addr;
    logic [31:0] data;
    int          cyc;
  } txn_t;

  txn_t       exp_q[$];
  logic [7:0] tx_q[$];
  int         checks = 0, failures = 0;
  int         cyc = 0;
  int         tx_mode = 2;   // 0 random ready, 1 toggling, 2 always ready, 3 never ready
  bit         held_valid = 0;
  logic [7:0] held_data;
  bit         rd_pend = 0;
  int         rd_cyc;
  logic [31:0] rd_val;
  bit         rd_force_en = 0;
  logic [31:0] rd_force;
  bit         ovr_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // regmap stand-in and output monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_pend && cyc == rd_cyc) begin
        lb_rdata = rd_val;
        rd_pend  = 0;
      end
      if (lb_wren || lb_rden) begin
        if (exp_q.size() == 0) chk_val("unexp_strobe", {lb_wren, lb_rden}, 2'b00);
        else begin
          txn_t t;
          t = exp_q.pop_front();
          chk_val("strobe_kind", {lb_wren, lb_rden}, t.rd ? 2'b01 : 2'b10);
          chk_val("strobe_cyc", cyc, t.cyc);
          chk_val("lb_ctrl", lb_ctrl, t.ctrl);
          chk_val("lb_addr", lb_addr, t.addr);
          if (!t.rd) chk_val("lb_wdata", lb_wdata, t.data);
          else begin
            rd_val   = rd_force_en ? rd_force : $urandom;
            lb_rdata = ~rd_val;
            rd_pend  = 1;
            rd_cyc   = cyc + RDLAT;
            tx_q.push_back(t.ctrl);
            for (int i = 3; i >= 0; i--) tx_q.push_back(rd_val[i*8 +: 8]);
          end
        end
      end
      case (tx_mode)
        0: tx_ready = 1'($urandom_range(0, 1));
        1: tx_ready = ~tx_ready;
        2: tx_ready = 1'b1;
        default: tx_ready = 1'b0;
      endcase
      if (held_valid) begin
        chk_val("tx_hold_valid", tx_valid, 1'b1);
        chk_val("tx_hold_data", tx_data, held_data);
      end
      if (tx_valid) begin
        if (tx_q.size() == 0) chk_val("unexp_tx", tx_valid, 1'b0);
        else if (tx_ready) chk_val("tx_byte", tx_data, tx_q.pop_front());
      end
      held_valid = tx_valid && !tx_ready;
      held_data  = tx_data;
    end
  end

  task automatic put_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic rx_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // gap < 0 picks a random 0..3 idle gap between bytes; nsend > 0 sends a truncated frame
  task automatic send_frame(input logic [7:0] ctrl, input logic [23:0] addr,
                            input logic [31:0] data, input int gap, input int nsend);
    logic [7:0] b[8];
    int n, lim;
    txn_t t;
    b[0] = ctrl;
    for (int i = 0; i < 3; i++) b[1+i] = addr[(2-i)*8 +: 8];
    for (int i = 0; i < 4; i++) b[4+i] = data[(3-i)*8 +: 8];
    n   = ctrl[0] ? 4 : 8;
    lim = (nsend > 0 && nsend < n) ? nsend : n;
    for (int i = 0; i < lim; i++) begin
      put_byte(b[i]);
      if (i < lim - 1) rx_idle(gap < 0 ? $urandom_range(0, 3) : gap);
    end
    if (lim == n) begin
      t.rd = ctrl[0]; t.ctrl = ctrl; t.addr = addr; t.data = data; t.cyc = cyc + 1;
      exp_q.push_back(t);
      rx_idle(1);
    end
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk_val("wait_idle", busy, 1'b0);
  endtask

  task automatic wait_tx(input int lim);
    int n = 0;
    while (!tx_valid && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk_val("wait_tx", tx_valid, 1'b1);
  endtask

  task automatic chk_zero(input string tag);
    chk_val({tag, "_tx"}, {tx_valid, tx_data}, 9'h0);
    chk_val({tag, "_ctrl"}, lb_ctrl, 8'h0);
    chk_val({tag, "_addr"}, lb_addr, 24'h0);
    chk_val({tag, "_wdata"}, lb_wdata, 32'h0);
    chk_val({tag, "_flags"}, {lb_wren, lb_rden, busy, overrun}, 4'h0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    rx_valid = 1'b0;
    #1 chk_zero(tag);
    exp_q.delete();
    tx_q.delete();
    held_valid = 0;
    rd_pend    = 0;
    ovr_exp    = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    #2 rst = 1'b0;

    // directed write
    send_frame(8'h00, 24'h123456, 32'hDEADBEEF, 0, 0);
    wait_idle(10);
    rx_idle(3);
    chk_val("hold_addr", lb_addr, 24'h123456);
    chk_val("hold_wdata", lb_wdata, 32'hDEADBEEF);

    // directed read, ready toggling
    rd_force_en = 1; rd_force = 32'hCAFEF00D; tx_mode = 1;
    send_frame(8'h01, 24'h000010, 32'h0, 0, 0);
    wait_idle(100);
    rd_force_en = 0;
    chk_val("read_tx_drained", tx_q.size(), 0);

    // timeout boundary then a good frame
    tx_mode = 2;
    put_byte(8'h00); put_byte(8'hAA);
    rx_idle(TIMEOUT);
    chk_val("pre_timeout_busy", busy, 1'b1);
    rx_idle(1);
    chk_val("post_timeout_idle", busy, 1'b0);
    rx_idle(3);
    send_frame(8'h00, 24'h000004, 32'h00000005, 0, 0);
    wait_idle(10);
    send_frame(8'h00, 24'h0A0B0C, 32'h11111111, TIMEOUT - 1, 0);
    wait_idle(10);

    // overrun during tx
    tx_mode = 1;
    send_frame(8'h01, 24'h000020, 32'h0, 0, 0);
    wait_tx(50);
    put_byte(8'h55);
    ovr_exp = 1;
    rx_idle(1);
    chk_val("overrun_set", overrun, 1'b1);
    wait_idle(100);
    tx_mode = 2;
    send_frame(8'h00, 24'hABCDEF, 32'h01234567, 0, 0);
    wait_idle(10);
    chk_val("overrun_sticky", overrun, 1'b1);

    // back-to-back write then read of the same address
    send_frame(8'h00, 24'h000123, 32'h11223344, 0, 0);
    send_frame(8'h01, 24'h000123, 32'h0, 0, 0);
    wait_idle(100);

    // reset mid write frame, and while a tx byte is pending
    put_byte(8'h00); put_byte(8'h12); put_byte(8'h34); put_byte(8'h56);
    put_byte(8'hDE); put_byte(8'hAD);
    do_reset("rst_wdata");
    tx_mode = 3;
    send_frame(8'h01, 24'h000040, 32'h0, 0, 0);
    wait_tx(50);
    do_reset("rst_tx");
    tx_mode = 2;
    send_frame(8'h01, 24'h000000, 32'h0, 0, 0);
    wait_idle(100);

    // randomized frames, with occasional truncated ones
    for (int k = 0; k < 40; k++) begin
      logic [7:0]  c;
      logic [23:0] a;
      logic [31:0] d;
      c = 8'($urandom);
      a = 24'($urandom);
      d = $urandom;
      tx_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 5) == 0) begin
        send_frame(c, a, d, -1, $urandom_range(1, c[0] ? 3 : 7));
        rx_idle(TIMEOUT + 2);
      end else begin
        send_frame(c, a, d, -1, 0);
        if (c[0]) wait_idle(200);
      end
    end
    wait_idle(200);
    repeat (5) @(negedge clk);
    chk_val("exp_q_empty", exp_q.size(), 0);
    chk_val("tx_q_empty", tx_q.size(), 0);
    chk_val("overrun_final", overrun, ovr_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
